// File: rtl/fir_stream_arbiter.sv
// fir_stream_arbiter: round-robin, credit-gated burst arbiter feeding one FIR cascade input
module fir_stream_arbiter #(
    parameter int DATA_WIDTH = 17,
    parameter int N_SRC      = 4,
    parameter int N_CREDITS  = 16,
    parameter int BURST      = 4,
    parameter int SRC_W      = $clog2(N_SRC),
    parameter int CRD_W      = $clog2(N_CREDITS + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_SRC-1:0]            i_valid,
    input  logic [N_SRC*DATA_WIDTH-1:0] i_data,
    output logic [N_SRC-1:0]            o_ready,
    output logic                        o_valid,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic [SRC_W-1:0]            o_src,
    input  logic                        i_credit,
    output logic [CRD_W-1:0]            o_credits,
    output logic                        o_busy,
    output logic                        o_overflow
);
    localparam int BW = $clog2(BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [SRC_W-1:0] grant, grant_nxt, rr_ptr, rr_nxt, sel, grant_inc;
    logic [BW-1:0]    burst_cnt, burst_nxt;
    logic [CRD_W-1:0] credits;
    logic             has_crd, xfer;

    assign has_crd   = credits != '0;
    assign xfer      = state == GRANT && has_crd && i_valid[grant];
    assign o_ready   = (state == GRANT && has_crd) ? {{(N_SRC-1){1'b0}}, 1'b1} << grant : '0;
    assign o_busy    = state == GRANT;
    assign o_credits = credits;
    assign grant_inc = (grant == SRC_W'(N_SRC - 1)) ? '0 : grant + SRC_W'(1);

    // pick the first requester at or above rr_ptr, wrapping; scanned downward so the nearest wins
    always_comb begin
        int idx;
        idx = 0;
        sel = rr_ptr;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (i_valid[idx[SRC_W-1:0]]) sel = idx[SRC_W-1:0];
        end
    end

    // next state: grant on any request, release on full burst or idle source, hold when out of credits
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
        burst_nxt = burst_cnt;
        if (state == IDLE) begin
            if (|i_valid) begin
                state_nxt = GRANT;
                grant_nxt = sel;
                burst_nxt = '0;
            end
        end else if (has_crd) begin
            if (!i_valid[grant]) begin
                state_nxt = IDLE;
                rr_nxt    = grant_inc;
            end else begin
                burst_nxt = burst_cnt + BW'(1);
                if (burst_cnt == BW'(BURST - 1)) begin
                    state_nxt = IDLE;
                    rr_nxt    = grant_inc;
                end
            end
        end
    end

    // arbitration state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // credit counter: spend on transfer, refund on pulse, flag a refund that would exceed the pool
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credits    <= CRD_W'(N_CREDITS);
            o_overflow <= 1'b0;
        end else if (xfer && !i_credit) begin
            credits <= credits - CRD_W'(1);
        end else if (i_credit && !xfer) begin
            if (credits == CRD_W'(N_CREDITS)) o_overflow <= 1'b1;
            else credits <= credits + CRD_W'(1);
        end
    end

    // output register: one-cycle valid per transfer, data and tag hold between transfers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_src   <= '0;
        end else begin
            o_valid <= xfer;
            if (xfer) begin
                o_data <= i_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                o_src  <= grant;
            end
        end
    end
endmodule

// File: tb/tb_fir_stream_arbiter.sv
// tb_fir_stream_arbiter: directed scenario checks for fir_stream_arbiter
module tb_fir_stream_arbiter;
    localparam int DW = 17;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam int CW = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    i_valid = '0;
    logic [N*DW-1:0] i_data = '0;
    logic [N-1:0]    o_ready;
    logic            o_valid;
    logic [DW-1:0]   o_data;
    logic [SW-1:0]   o_src;
    logic            i_credit = 1'b0;
    logic [CW-1:0]   o_credits;
    logic            o_busy;
    logic            o_overflow;

    int checks = 0;
    int fails  = 0;

    logic [DW-1:0] q[N][$];

    fir_stream_arbiter dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_src(o_src),
        .i_credit(i_credit), .o_credits(o_credits), .o_busy(o_busy), .o_overflow(o_overflow)
    );

    always #5 clock = ~clock;

    // present each source queue head
    task automatic drive();
        for (int k = 0; k < N; k++) begin
            i_valid[k] = q[k].size() > 0;
            i_data[k*DW +: DW] = (q[k].size() > 0) ? q[k][0] : '0;
        end
    endtask

    // one clock: note handshakes before the edge, pop accepted words after it
    task automatic tick();
        logic [N-1:0] fire;
        drive();
        fire = o_ready & i_valid;
        @(posedge clock);
        #1;
        for (int k = 0; k < N; k++)
            if (fire[k]) void'(q[k].pop_front());
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_credit = 1'b0;
        for (int k = 0; k < N; k++) q[k].delete();
        drive();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (o_ready !== 4'b0 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake: ready=%b valid=%b expected 0000/0", o_ready, o_valid);
        end
        checks++;
        if (o_data !== 17'd0 || o_src !== 2'd0) begin
            fails++;
            $display("FAIL reset_data: data=%h src=%0d expected 0/0", o_data, o_src);
        end
        checks++;
        if (o_credits !== 5'd16 || o_busy !== 1'b0 || o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: credits=%0d busy=%b ovf=%b expected 16/0/0", o_credits, o_busy, o_overflow);
        end
    endtask

    task automatic test_single_source();
        logic [DW-1:0] exp_d[9] = '{17'h0, 17'hA1, 17'hA2, 17'hA3, 17'hA4, 17'h0, 17'hA5, 17'hA6, 17'h0};
        logic          exp_v[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        i_credit = 1'b1;
        for (int j = 0; j < 6; j++) q[2].push_back(DW'(17'hA1 + j));
        for (int c = 0; c < 9; c++) begin
            tick();
            checks++;
            if (o_valid !== exp_v[c] || (exp_v[c] && (o_data !== exp_d[c] || o_src !== 2'd2))) begin
                fails++;
                $display("FAIL single_cycle%0d: valid=%b data=%h src=%0d expected %b/%h/2", c, o_valid, o_data, o_src, exp_v[c], exp_d[c]);
            end
        end
        checks++;
        if (o_credits !== 5'd16) begin
            fails++;
            $display("FAIL single_credits: got %0d expected 16", o_credits);
        end
    endtask

    task automatic test_contention();
        int pos, g;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        do_reset();
        i_credit = 1'b1;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 30; j++) q[k].push_back(DW'(k*256 + j));
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL contention_first: valid=%b expected 0", o_valid);
        end
        for (int c = 2; c < 27; c++) begin
            tick();
            pos = (c - 2) % 5;
            g   = (c - 2) / 5;
            es  = SW'(g % 4);
            ed  = DW'((g % 4)*256 + (g / 4)*4 + pos);
            checks++;
            if (o_valid !== (pos < 4) || (pos < 4 && (o_src !== es || o_data !== ed))) begin
                fails++;
                $display("FAIL contention_cycle%0d: valid=%b src=%0d data=%h expected %b/%0d/%h", c, o_valid, o_src, o_data, pos < 4, es, ed);
            end
        end
        checks++;
        if (o_credits !== 5'd16) begin
            fails++;
            $display("FAIL contention_credits: got %0d expected 16", o_credits);
        end
    endtask

    task automatic test_credit_exhaustion();
        int n;
        do_reset();
        for (int j = 0; j < 40; j++) q[0].push_back(DW'(j));
        repeat (21) tick();
        checks++;
        if (o_credits !== 5'd0 || o_ready !== 4'b0 || o_busy !== 1'b1) begin
            fails++;
            $display("FAIL exhaust_stall: credits=%0d ready=%b busy=%b expected 0/0000/1", o_credits, o_ready, o_busy);
        end
        repeat (4) tick();
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b1 || q[0].size() != 24) begin
            fails++;
            $display("FAIL exhaust_hold: valid=%b busy=%b left=%0d expected 0/1/24", o_valid, o_busy, q[0].size());
        end
        i_credit = 1'b1;
        tick();
        i_credit = 1'b0;
        checks++;
        if (o_credits !== 5'd1 || o_ready !== 4'b0001) begin
            fails++;
            $display("FAIL exhaust_refund: credits=%0d ready=%b expected 1/0001", o_credits, o_ready);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 17'd16 || o_credits !== 5'd0) begin
            fails++;
            $display("FAIL exhaust_one_more: valid=%b data=%h credits=%0d expected 1/10/0", o_valid, o_data, o_credits);
        end
        n = 0;
        repeat (5) begin
            tick();
            if (o_valid) n++;
        end
        checks++;
        if (n != 0 || o_ready !== 4'b0) begin
            fails++;
            $display("FAIL exhaust_extra: extra=%0d ready=%b expected 0/0000", n, o_ready);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int j = 0; j < 40; j++) q[0].push_back(DW'(j));
        repeat (14) tick();
        checks++;
        if (o_credits !== 5'd5) begin
            fails++;
            $display("FAIL simul_pre: credits=%0d expected 5", o_credits);
        end
        i_credit = 1'b1;
        tick();
        i_credit = 1'b0;
        checks++;
        if (o_credits !== 5'd5 || o_valid !== 1'b1 || o_data !== 17'd11) begin
            fails++;
            $display("FAIL simul_both: credits=%0d valid=%b data=%h expected 5/1/b", o_credits, o_valid, o_data);
        end
        do_reset();
        checks++;
        if (o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL overflow_pre: got %b expected 0", o_overflow);
        end
        i_credit = 1'b1;
        tick();
        i_credit = 1'b0;
        checks++;
        if (o_credits !== 5'd16 || o_overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_set: credits=%0d ovf=%b expected 16/1", o_credits, o_overflow);
        end
        repeat (3) tick();
        checks++;
        if (o_credits !== 5'd16 || o_overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sticky: credits=%0d ovf=%b expected 16/1", o_credits, o_overflow);
        end
    endtask

    task automatic test_early_release();
        do_reset();
        q[1].push_back(17'h110);
        q[1].push_back(17'h111);
        for (int j = 0; j < 6; j++) q[3].push_back(DW'(17'h130 + j));
        tick();
        checks++;
        if (o_ready !== 4'b0010) begin
            fails++;
            $display("FAIL early_grant1: ready=%b expected 0010", o_ready);
        end
        tick();
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_src !== 2'd1 || o_data !== 17'h111) begin
            fails++;
            $display("FAIL early_word2: valid=%b src=%0d data=%h expected 1/1/111", o_valid, o_src, o_data);
        end
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || dut.rr_ptr !== 2'd2) begin
            fails++;
            $display("FAIL early_release: busy=%b valid=%b rr=%0d expected 0/0/2", o_busy, o_valid, dut.rr_ptr);
        end
        tick();
        checks++;
        if (o_ready !== 4'b1000) begin
            fails++;
            $display("FAIL early_grant3: ready=%b expected 1000", o_ready);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_src !== 2'd3 || o_data !== 17'h130) begin
            fails++;
            $display("FAIL early_src3: valid=%b src=%0d data=%h expected 1/3/130", o_valid, o_src, o_data);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int j = 0; j < 40; j++) q[1].push_back(DW'(17'h100 + j));
        repeat (9) tick();
        for (int j = 0; j < 10; j++) q[3].push_back(DW'(17'h300 + j));
        drive();
        checks++;
        if (o_credits !== 5'd9 || o_ready !== 4'b0010 || o_valid !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre: credits=%0d ready=%b valid=%b expected 9/0010/1", o_credits, o_ready, o_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (o_ready !== 4'b0 || o_valid !== 1'b0 || o_credits !== 5'd16 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL midrst_async: ready=%b valid=%b credits=%0d busy=%b expected 0000/0/16/0", o_ready, o_valid, o_credits, o_busy);
        end
        #1;
        reset = 1'b0;
        tick();
        checks++;
        if (o_ready !== 4'b0010) begin
            fails++;
            $display("FAIL midrst_regrant: ready=%b expected 0010", o_ready);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_src !== 2'd1 || o_data !== 17'h107) begin
            fails++;
            $display("FAIL midrst_word: valid=%b src=%0d data=%h expected 1/1/107", o_valid, o_src, o_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_contention();
        test_credit_exhaustion();
        test_simultaneous();
        test_early_release();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
